// File: rtl/spmc_spi_slave_pkg.sv
// Shared definitions for the SpartanMC SPI slave peripheral:
// register offsets, STATUS/CTRL bit positions and frame FSM states.
package spmc_spi_slave_pkg;

  localparam logic [5:0] REG_DATA   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_CTRL   = 6'd2;

  localparam int unsigned SB_RX_NEMPTY = 0;
  localparam int unsigned SB_RX_FULL   = 1;
  localparam int unsigned SB_TX_NEMPTY = 2;
  localparam int unsigned SB_TX_FULL   = 3;
  localparam int unsigned SB_FLAG_LSB  = 4;
  localparam int unsigned SB_CS_ACT    = 8;

  localparam int unsigned CB_EN     = 0;
  localparam int unsigned CB_IRQ_EN = 1;
  localparam int unsigned CB_FLUSH  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } frame_state_e;

  // Sticky flags, packed in STATUS[7:4] order
  typedef struct packed {
    logic tx_ovf;
    logic frame_err;
    logic tx_undr;
    logic rx_ovf;
  } flags_t;

endpackage

// File: rtl/spmc_spi_slave_fifo.sv
// Byte FIFO with push/pop/flush; push is accepted when full
// if a pop happens in the same cycle. Flush overrides both.
module spmc_spi_slave_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH[AW:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/spmc_spi_slave.sv
// SPI mode-0 slave on the SpartanMC peripheral bus with RX/TX
// byte FIFOs; all SPI pins are oversampled in clk_peri.
module spmc_spi_slave
  import spmc_spi_slave_pkg::*;
#(
  parameter logic [9:0]  BASE_ADR   = 10'h0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic [2:0]   sclk_q;
  logic [2:0]   cs_q;
  logic [1:0]   mosi_q;
  logic         sclk_rise;
  logic         sclk_fall;
  logic         cs_s;
  logic         cs_rise;
  logic         cs_fall;
  logic         mosi_s;

  frame_state_e state_q;
  frame_state_e state_d;
  logic [2:0]   bitcnt_q;
  logic [2:0]   bitcnt_d;
  logic [7:0]   tx_sr_q;
  logic [7:0]   tx_sr_d;
  logic [7:0]   rx_sr_q;
  logic [7:0]   rx_sr_d;
  logic         load_tx;
  logic         tx_pop;
  logic         rx_push;
  logic         undr_set;
  logic         ferr_set;

  logic         enable_q;
  logic         irq_en_q;
  logic         armed_q;
  logic         irq_q;
  logic [17:0]  di_q;
  logic [17:0]  rdata;
  logic [17:0]  status;
  flags_t       flags_q;
  flags_t       flags_set;
  flags_t       flags_clr;

  logic         sel;
  logic [5:0]   off;
  logic         rd_sel;
  logic         wr_data;
  logic         wr_status;
  logic         wr_ctrl;
  logic         flush;
  logic         en_rise;
  logic         cpu_pop;

  logic [7:0]   rx_head;
  logic         rx_full;
  logic         rx_empty;
  logic [7:0]   tx_head;
  logic         tx_full;
  logic         tx_empty;
  logic         unused_hi;

  assign unused_hi = ^do_peri[17:8];

  // cs sync resets to "asserted" so a frame is never armed from reset values
  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  assign sel       = access_peri & (addr_peri[9:6] == BASE_ADR[9:6]);
  assign off       = addr_peri[5:0];
  assign rd_sel    = sel & ~wr_peri;
  assign wr_data   = sel & wr_peri & (off == REG_DATA);
  assign wr_status = sel & wr_peri & (off == REG_STATUS);
  assign wr_ctrl   = sel & wr_peri & (off == REG_CTRL);
  assign flush     = wr_ctrl & do_peri[CB_FLUSH];
  assign en_rise   = wr_ctrl & do_peri[CB_EN] & ~enable_q;
  assign cpu_pop   = rd_sel & (off == REG_DATA) & ~rx_empty;

  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    load_tx  = 1'b0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    undr_set = 1'b0;
    ferr_set = 1'b0;
    if (!enable_q) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall && armed_q) begin
            state_d  = ST_ACTIVE;
            bitcnt_d = '0;
            load_tx  = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_d  = ST_IDLE;
            ferr_set = (bitcnt_q != 3'd0);
            bitcnt_d = '0;
          end else if (sclk_rise) begin
            rx_sr_d = {rx_sr_q[6:0], mosi_s};
            if (bitcnt_q == 3'd7) begin
              rx_push  = 1'b1;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else if (sclk_fall) begin
            if (bitcnt_q == 3'd0) begin
              load_tx = 1'b1;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load_tx) begin
      if (tx_empty) begin
        tx_sr_d  = FILL_BYTE;
        undr_set = 1'b1;
      end else begin
        tx_sr_d = tx_head;
        tx_pop  = 1'b1;
      end
    end
  end

  spmc_spi_slave_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (clk_peri),
    .rst_ni (reset),
    .push_i (rx_push),
    .data_i (rx_sr_d),
    .pop_i  (cpu_pop),
    .flush_i(flush),
    .head_o (rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  spmc_spi_slave_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i  (clk_peri),
    .rst_ni (reset),
    .push_i (wr_data),
    .data_i (do_peri[7:0]),
    .pop_i  (tx_pop),
    .flush_i(flush),
    .head_o (tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  // A byte lost to a concurrent flush raises no flag
  always_comb begin
    flags_set           = '0;
    flags_set.rx_ovf    = rx_push & rx_full & ~cpu_pop & ~flush;
    flags_set.tx_undr   = undr_set;
    flags_set.frame_err = ferr_set;
    flags_set.tx_ovf    = wr_data & tx_full & ~tx_pop;
    flags_clr           = '0;
    if (wr_status) begin
      flags_clr = flags_t'(do_peri[7:4]);
    end
  end

  always_comb begin
    status                              = '0;
    status[SB_RX_NEMPTY]                = ~rx_empty;
    status[SB_RX_FULL]                  = rx_full;
    status[SB_TX_NEMPTY]                = ~tx_empty;
    status[SB_TX_FULL]                  = tx_full;
    status[SB_FLAG_LSB+3:SB_FLAG_LSB]   = flags_q;
    status[SB_CS_ACT]                   = ~cs_s;
  end

  always_comb begin
    rdata = '0;
    if (rd_sel) begin
      unique case (1'b1)
        (off == REG_DATA):   rdata = {10'b0, (rx_empty ? 8'h00 : rx_head)};
        (off == REG_STATUS): rdata = status;
        (off == REG_CTRL):   rdata = {16'b0, irq_en_q, enable_q};
        default:             rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      armed_q  <= 1'b0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
      di_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= do_peri[CB_EN];
        irq_en_q <= do_peri[CB_IRQ_EN];
      end
      if (en_rise && !cs_s) begin
        armed_q <= 1'b0;
      end else if (cs_s) begin
        armed_q <= 1'b1;
      end
      flags_q <= flags_t'((flags_q & ~flags_clr) | flags_set);
      irq_q   <= irq_en_q & (~rx_empty | (|flags_q));
      di_q    <= rdata;
    end
  end

  assign di_peri     = di_q;
  assign irq         = irq_q;
  assign spi_miso    = (state_q == ST_ACTIVE) ? tx_sr_q[7] : 1'b1;
  assign spi_miso_oe = enable_q & ~cs_s;

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Directed bench for spmc_spi_slave: an SPI master model at
// clk/8 plus CPU bus tasks, each scenario checking inline.
module tb_spmc_spi_slave;

  logic        clk;
  logic        reset;
  logic [17:0] do_peri;
  logic [17:0] di_peri;
  logic [9:0]  addr_peri;
  logic        access_peri;
  logic        wr_peri;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        irq;

  int errors;
  int checks;

  localparam logic [9:0] A_DATA = 10'd0;
  localparam logic [9:0] A_STAT = 10'd1;
  localparam logic [9:0] A_CTRL = 10'd2;

  spmc_spi_slave dut (
    .clk_peri   (clk),
    .reset      (reset),
    .do_peri    (do_peri),
    .di_peri    (di_peri),
    .addr_peri  (addr_peri),
    .access_peri(access_peri),
    .wr_peri    (wr_peri),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic bus_wr(input logic [9:0] a, input logic [17:0] d);
    @(negedge clk);
    addr_peri = a; do_peri = d; wr_peri = 1'b1; access_peri = 1'b1;
    @(negedge clk);
    access_peri = 1'b0; wr_peri = 1'b0;
  endtask

  task automatic bus_rd(input logic [9:0] a, output logic [17:0] d);
    @(negedge clk);
    addr_peri = a; wr_peri = 1'b0; access_peri = 1'b1;
    @(negedge clk);
    access_peri = 1'b0;
    d = di_peri;
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [17:0] d;
    checks++;
    if (di_peri !== 18'h0 || spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got di=%h miso=%b oe=%b irq=%b exp 0/1/0/0",
               di_peri, spi_miso, spi_miso_oe, irq);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    bus_rd(10'd3, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", d); end
  endtask

  task automatic test_basic();
    logic [17:0] d;
    logic [7:0]  mi;
    bus_wr(A_CTRL, 18'h1);
    bus_wr(A_DATA, 18'h0A5);
    cs_begin();
    checks++;
    if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe got=%b exp=1", spi_miso_oe); end
    spi_bits(8'h3C, 8, mi);
    cs_end();
    checks++;
    if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso got=%h exp=a5", mi); end
    checks++;
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_off got=%b exp=0", spi_miso_oe); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h021) begin errors++; $display("FAIL basic_status got=%h exp=021", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h03C) begin errors++; $display("FAIL basic_data got=%h exp=03c", d); end
    @(negedge clk);
    checks++;
    if (di_peri !== 18'h0) begin errors++; $display("FAIL basic_di_idle got=%h exp=0", di_peri); end
    bus_rd({4'd1, A_STAT[5:0]}, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL other_base got=%h exp=0", d); end
    bus_wr(A_STAT, 18'h020);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL basic_status2 got=%h exp=0", d); end
  endtask

  task automatic test_underrun();
    logic [17:0] d;
    logic [7:0]  m0;
    logic [7:0]  m1;
    cs_begin();
    spi_bits(8'h11, 8, m0);
    spi_bits(8'h22, 8, m1);
    cs_end();
    checks++;
    if (m0 !== 8'hFF || m1 !== 8'hFF) begin
      errors++; $display("FAIL undr_miso got=%h,%h exp=ff,ff", m0, m1);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h021) begin errors++; $display("FAIL undr_status got=%h exp=021", d); end
    bus_wr(A_STAT, 18'h020);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h001) begin errors++; $display("FAIL undr_clear got=%h exp=001", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h011) begin errors++; $display("FAIL undr_rx0 got=%h exp=011", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h022) begin errors++; $display("FAIL undr_rx1 got=%h exp=022", d); end
  endtask

  task automatic test_rx_overflow();
    logic [17:0] d;
    logic [7:0]  mi;
    cs_begin();
    for (int i = 1; i <= 5; i++) spi_bits(8'(i), 8, mi);
    cs_end();
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h033) begin errors++; $display("FAIL rxovf_status got=%h exp=033", d); end
    for (int i = 1; i <= 4; i++) begin
      bus_rd(A_DATA, d);
      checks++;
      if (d !== 18'(i)) begin errors++; $display("FAIL rxovf_data%0d got=%h exp=%h", i, d, 18'(i)); end
    end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL rxovf_empty got=%h exp=0", d); end
    bus_wr(A_STAT, 18'h030);
  endtask

  task automatic test_tx_ovf_flush();
    logic [17:0] d;
    for (int i = 0; i < 5; i++) bus_wr(A_DATA, 18'h040 + 18'(i));
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h08C) begin errors++; $display("FAIL txovf_status got=%h exp=08c", d); end
    bus_wr(A_CTRL, 18'h5);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h080) begin errors++; $display("FAIL flush_status got=%h exp=080", d); end
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 18'h001) begin errors++; $display("FAIL flush_ctrl got=%h exp=001", d); end
    bus_wr(A_STAT, 18'h080);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h0) begin errors++; $display("FAIL txovf_clear got=%h exp=0", d); end
  endtask

  task automatic test_frame_err();
    logic [17:0] d;
    logic [7:0]  mi;
    cs_begin();
    spi_bits(8'hE0, 3, mi);
    cs_end();
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h060) begin errors++; $display("FAIL ferr_status got=%h exp=060", d); end
    cs_begin();
    spi_bits(8'h81, 8, mi);
    cs_end();
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h081) begin errors++; $display("FAIL ferr_next got=%h exp=081", d); end
    bus_wr(A_STAT, 18'h060);
  endtask

  task automatic test_reset_midframe();
    logic [17:0] d;
    logic [7:0]  mi;
    bus_wr(A_DATA, 18'h05A);
    cs_begin();
    spi_bits(8'hF0, 3, mi);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (di_peri !== 18'h0 || spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got di=%h miso=%b oe=%b irq=%b exp 0/1/0/0",
               di_peri, spi_miso, spi_miso_oe, irq);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    bus_wr(A_CTRL, 18'h1);
    repeat (4) @(negedge clk);
    spi_bits(8'h77, 8, mi);
    repeat (6) @(negedge clk);
    checks++;
    if (spi_miso !== 1'b1) begin errors++; $display("FAIL midrst_miso got=%b exp=1", spi_miso); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h100) begin errors++; $display("FAIL midrst_noarm got=%h exp=100", d); end
    cs_end();
    cs_begin();
    spi_bits(8'h42, 8, mi);
    cs_end();
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h021) begin errors++; $display("FAIL midrst_status got=%h exp=021", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h042) begin errors++; $display("FAIL midrst_data got=%h exp=042", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
    bus_wr(A_STAT, 18'h020);
  endtask

  task automatic test_irq_pushpop();
    logic [17:0] d;
    logic [17:0] rd;
    logic [7:0]  mi;
    logic [7:0]  mo;
    bus_wr(A_CTRL, 18'h3);
    bus_wr(A_DATA, 18'h012);
    bus_wr(A_DATA, 18'h034);
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq); end
    cs_begin();
    spi_bits(8'h99, 8, mi);
    cs_end();
    checks++;
    if (mi !== 8'h12) begin errors++; $display("FAIL irq_miso got=%h exp=12", mi); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h099) begin errors++; $display("FAIL irq_data got=%h exp=099", d); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_wr(A_DATA, 18'h056);
    bus_wr(A_DATA, 18'h078);
    cs_begin();
    spi_bits(8'hAB, 8, mi);
    checks++;
    if (mi !== 8'h56) begin errors++; $display("FAIL pp_miso0 got=%h exp=56", mi); end
    mo = 8'hCD;
    rd = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 0) begin
        repeat (2) @(negedge clk);
        addr_peri = A_DATA; wr_peri = 1'b0; access_peri = 1'b1;
        @(negedge clk);
        access_peri = 1'b0;
        rd = di_peri;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sclk = 1'b0;
    end
    cs_end();
    checks++;
    if (mi !== 8'h78) begin errors++; $display("FAIL pp_miso1 got=%h exp=78", mi); end
    checks++;
    if (rd !== 18'h0AB) begin errors++; $display("FAIL pp_rd got=%h exp=0ab", rd); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h021) begin errors++; $display("FAIL pp_status got=%h exp=021", d); end
    bus_rd(A_DATA, d);
    checks++;
    if (d !== 18'h0CD) begin errors++; $display("FAIL pp_data got=%h exp=0cd", d); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 18'h020) begin errors++; $display("FAIL pp_empty got=%h exp=020", d); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    do_peri = '0;
    addr_peri = '0;
    access_peri = 1'b0;
    wr_peri = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    test_basic();
    test_underrun();
    test_rx_overflow();
    test_tx_ovf_flush();
    test_frame_err();
    test_reset_midframe();
    test_irq_pushpop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
